// File: rtl/bcd_to_binary_pkg.sv
// Shared definitions for the BCD-to-binary display path: FSM state encoding,
// default sizing and the BCD radix.
package bcd_to_binary_pkg;

  localparam int DEF_BIT_SIZE = 20;
  localparam int DEF_DIGITS   = 6;
  localparam int BCD_RADIX    = 10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_CONV   = 2'd1;
  localparam state_t ST_FINISH = 2'd2;

  // A nibble is a legal BCD digit only below the radix.
  function automatic logic bcd_digit_invalid(input logic [3:0] digit);
    return (digit > 4'(BCD_RADIX - 1));
  endfunction

endpackage : bcd_to_binary_pkg

// File: rtl/bcd_to_binary_mac.sv
// One Horner step of the BCD conversion: acc*10 + digit via shift-add, plus a
// flag for digits outside 0..9.
module bcd_mac_step
  import bcd_to_binary_pkg::*;
#(
  parameter int ACC_W = DEF_BIT_SIZE + 1
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] acc_next,
  output logic             digit_invalid
);

  logic [ACC_W-1:0] times8_s;
  logic [ACC_W-1:0] times2_s;
  logic [ACC_W-1:0] digit_ext_s;

  assign times8_s    = acc << 3;
  assign times2_s    = acc << 1;
  assign digit_ext_s = {{(ACC_W-4){1'b0}}, digit};

  assign acc_next      = times8_s + times2_s + digit_ext_s;
  assign digit_invalid = bcd_digit_invalid(digit);

endmodule : bcd_mac_step

// File: rtl/bcd_to_binary.sv
// Sequential BCD to signed binary converter: one digit per clock, MSD first,
// with sign application and saturation to the signed BIT_SIZE range.
module bcd_to_binary
  import bcd_to_binary_pkg::*;
#(
  parameter int BIT_SIZE = DEF_BIT_SIZE,
  parameter int DIGITS   = DEF_DIGITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [4*DIGITS-1:0]        bcd_in,
  input  logic                       negative,
  output logic signed [BIT_SIZE-1:0] number,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic                       overflow
);

  localparam int ACC_W = BIT_SIZE + 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [ACC_W-1:0] POS_MAX = {2'b00, {(BIT_SIZE-1){1'b1}}};
  localparam logic [ACC_W-1:0] NEG_MAG = {2'b01, {(BIT_SIZE-1){1'b0}}};
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

  state_t                     state_r;
  logic [4*DIGITS-1:0]        bcd_r;
  logic                       neg_r;
  logic [ACC_W-1:0]           acc_r;
  logic [IDX_W-1:0]           idx_r;
  logic                       invalid_r;
  logic signed [BIT_SIZE-1:0] number_r;
  logic                       busy_r;
  logic                       done_r;
  logic                       error_r;
  logic                       overflow_r;

  logic [3:0]                 digit_s;
  logic [ACC_W-1:0]           acc_next_s;
  logic                       digit_bad_s;
  logic [BIT_SIZE-1:0]        mag_s;
  logic signed [BIT_SIZE-1:0] res_number_s;
  logic                       res_error_s;
  logic                       res_overflow_s;

  assign digit_s = bcd_r[{idx_r, 2'b00} +: 4];
  assign mag_s   = acc_r[BIT_SIZE-1:0];

  bcd_mac_step #(
    .ACC_W (ACC_W)
  ) u_mac (
    .acc           (acc_r),
    .digit         (digit_s),
    .acc_next      (acc_next_s),
    .digit_invalid (digit_bad_s)
  );

  // Final result selection: invalid digits win, then saturation, then signed value.
  always_comb begin
    res_number_s   = '0;
    res_error_s    = 1'b0;
    res_overflow_s = 1'b0;
    if (invalid_r) begin
      res_error_s = 1'b1;
    end else if (!neg_r && (acc_r > POS_MAX)) begin
      res_number_s   = POS_MAX[BIT_SIZE-1:0];
      res_overflow_s = 1'b1;
    end else if (neg_r && (acc_r > NEG_MAG)) begin
      res_number_s   = NEG_MAG[BIT_SIZE-1:0];
      res_overflow_s = 1'b1;
    end else if (neg_r) begin
      // Two's-complement negation also maps -0 to 0 and -2^(BIT_SIZE-1) to itself.
      res_number_s = -mag_s;
    end else begin
      res_number_s = mag_s;
    end
  end

  // Conversion FSM, operand latches and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      bcd_r      <= '0;
      neg_r      <= 1'b0;
      acc_r      <= '0;
      idx_r      <= '0;
      invalid_r  <= 1'b0;
      number_r   <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            bcd_r     <= bcd_in;
            neg_r     <= negative;
            acc_r     <= '0;
            idx_r     <= IDX_TOP;
            invalid_r <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= ST_CONV;
          end
        end
        ST_CONV: begin
          acc_r     <= acc_next_s;
          invalid_r <= invalid_r | digit_bad_s;
          if (idx_r == {IDX_W{1'b0}}) begin
            state_r <= ST_FINISH;
          end else begin
            idx_r <= idx_r - IDX_W'(1);
          end
        end
        ST_FINISH: begin
          number_r   <= res_number_s;
          error_r    <= res_error_s;
          overflow_r <= res_overflow_s;
          done_r     <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign number   = number_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign error    = error_r;
  assign overflow = overflow_r;

endmodule : bcd_to_binary

// File: tb/tb_bcd_to_binary.sv
// Directed self-checking bench for bcd_to_binary with default parameters.
module tb_bcd_to_binary;

  logic               clk;
  logic               rst;
  logic               start;
  logic [23:0]        bcd_in;
  logic               negative;
  logic signed [19:0] number;
  logic               busy;
  logic               done;
  logic               error;
  logic               overflow;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  bcd_to_binary #(
    .BIT_SIZE (20),
    .DIGITS   (6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bcd_in   (bcd_in),
    .negative (negative),
    .number   (number),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands for one edge, then scramble them to show they are latched.
  task automatic start_conv(input logic [23:0] b, input logic n);
    bcd_in   = b;
    negative = n;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    bcd_in   = 24'hABCDEF;
    negative = ~n;
  endtask

  // Count edges after the start edge until done; -1 if it never arrives.
  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    bcd_in = 24'h0;
    negative = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++; if (number !== 20'sd0) $display("FAIL reset_number: got %0d expected 0", number); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
    chk_cnt++; if (error !== 1'b0) $display("FAIL reset_error: got %b expected 0", error); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else pass_cnt++;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int cyc;
    start_conv(24'h123456, 1'b0);
    chk_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b expected 1", busy); else pass_cnt++;
    wait_done(cyc);
    chk_cnt++; if (cyc != 7) $display("FAIL basic_latency: got %0d expected 7", cyc); else pass_cnt++;
    chk_cnt++; if (number !== 20'sd123456) $display("FAIL basic_number: got %0d expected 123456", number); else pass_cnt++;
    chk_cnt++; if (error !== 1'b0 || overflow !== 1'b0) $display("FAIL basic_flags: got err=%b ovf=%b expected 0 0", error, overflow); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b expected 0", busy); else pass_cnt++;
    @(posedge clk);
    #1;
    chk_cnt++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b expected 0", done); else pass_cnt++;
    chk_cnt++; if (number !== 20'sd123456) $display("FAIL basic_hold: got %0d expected 123456", number); else pass_cnt++;
  endtask

  task automatic test_sign();
    int cyc;
    start_conv(24'h000042, 1'b1);
    wait_done(cyc);
    chk_cnt++; if (cyc != 7) $display("FAIL neg42_latency: got %0d expected 7", cyc); else pass_cnt++;
    chk_cnt++; if (number !== -20'sd42) $display("FAIL neg42_number: got %0d expected -42", number); else pass_cnt++;
    start_conv(24'h000000, 1'b1);
    wait_done(cyc);
    chk_cnt++; if (number !== 20'sd0) $display("FAIL negzero_number: got %0d expected 0", number); else pass_cnt++;
    chk_cnt++; if (error !== 1'b0 || overflow !== 1'b0) $display("FAIL negzero_flags: got err=%b ovf=%b expected 0 0", error, overflow); else pass_cnt++;
  endtask

  task automatic test_saturation();
    int cyc;
    start_conv(24'h999999, 1'b0);
    wait_done(cyc);
    chk_cnt++; if (number !== 20'sd524287) $display("FAIL pos_sat_number: got %0d expected 524287", number); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b1) $display("FAIL pos_sat_overflow: got %b expected 1", overflow); else pass_cnt++;
    start_conv(24'h524288, 1'b1);
    wait_done(cyc);
    chk_cnt++; if (number !== 20'sh80000) $display("FAIL neg_min_number: got %0d expected -524288", number); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b0) $display("FAIL neg_min_overflow: got %b expected 0", overflow); else pass_cnt++;
    start_conv(24'h524289, 1'b1);
    wait_done(cyc);
    chk_cnt++; if (number !== 20'sh80000 || overflow !== 1'b1) $display("FAIL neg_sat: got %0d ovf=%b expected -524288 ovf=1", number, overflow); else pass_cnt++;
    start_conv(24'h524287, 1'b0);
    wait_done(cyc);
    chk_cnt++; if (number !== 20'sd524287 || overflow !== 1'b0) $display("FAIL pos_max: got %0d ovf=%b expected 524287 ovf=0", number, overflow); else pass_cnt++;
    start_conv(24'h524288, 1'b0);
    wait_done(cyc);
    chk_cnt++; if (number !== 20'sd524287 || overflow !== 1'b1) $display("FAIL pos_over_by_one: got %0d ovf=%b expected 524287 ovf=1", number, overflow); else pass_cnt++;
  endtask

  task automatic test_error();
    int cyc;
    start_conv(24'h12A456, 1'b0);
    wait_done(cyc);
    chk_cnt++; if (cyc != 7) $display("FAIL err_latency: got %0d expected 7", cyc); else pass_cnt++;
    chk_cnt++; if (error !== 1'b1) $display("FAIL err_flag: got %b expected 1", error); else pass_cnt++;
    chk_cnt++; if (number !== 20'sd0 || overflow !== 1'b0) $display("FAIL err_result: got %0d ovf=%b expected 0 ovf=0", number, overflow); else pass_cnt++;
    start_conv(24'h00000F, 1'b1);
    wait_done(cyc);
    chk_cnt++; if (error !== 1'b1 || number !== 20'sd0) $display("FAIL err_units: got err=%b num=%0d expected err=1 num=0", error, number); else pass_cnt++;
    start_conv(24'h000007, 1'b0);
    wait_done(cyc);
    chk_cnt++; if (error !== 1'b0 || number !== 20'sd7) $display("FAIL err_clear: got err=%b num=%0d expected err=0 num=7", error, number); else pass_cnt++;
  endtask

  task automatic test_ignore_start();
    logic busy_ok;
    logic done_early;
    busy_ok = 1'b1;
    done_early = 1'b0;
    start_conv(24'h111111, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      if (k == 3) begin
        start    = 1'b1;
        bcd_in   = 24'h222222;
        negative = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done !== 1'b0) done_early = 1'b1;
    end
    chk_cnt++; if (busy_ok !== 1'b1) $display("FAIL ignore_busy: got busy low in cycles 1-6 expected high"); else pass_cnt++;
    chk_cnt++; if (done_early !== 1'b0) $display("FAIL ignore_done_early: got done before cycle 7 expected none"); else pass_cnt++;
    @(posedge clk);
    #1;
    chk_cnt++; if (done !== 1'b1) $display("FAIL ignore_done: got %b expected 1 at cycle 7", done); else pass_cnt++;
    chk_cnt++; if (number !== 20'sd111111) $display("FAIL ignore_number: got %0d expected 111111", number); else pass_cnt++;
    @(posedge clk);
    #1;
    chk_cnt++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL ignore_second: got busy=%b done=%b expected 0 0", busy, done); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_conv(24'h000100, 1'b0);
    wait_done(cyc);
    chk_cnt++; if (number !== 20'sd100) $display("FAIL b2b_first: got %0d expected 100", number); else pass_cnt++;
    start_conv(24'h000200, 1'b1);
    chk_cnt++; if (busy !== 1'b1) $display("FAIL b2b_accept: got busy=%b expected 1", busy); else pass_cnt++;
    wait_done(cyc);
    chk_cnt++; if (cyc != 7) $display("FAIL b2b_latency: got %0d expected 7", cyc); else pass_cnt++;
    chk_cnt++; if (number !== -20'sd200) $display("FAIL b2b_second: got %0d expected -200", number); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int  cyc;
    logic saw_done;
    saw_done = 1'b0;
    start_conv(24'h999999, 1'b0);
    wait_done(cyc);
    start_conv(24'h000321, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else pass_cnt++;
    chk_cnt++; if (number !== 20'sd0) $display("FAIL abort_number: got %0d expected 0", number); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b0 || error !== 1'b0 || done !== 1'b0) $display("FAIL abort_flags: got ovf=%b err=%b done=%b expected 0 0 0", overflow, error, done); else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) saw_done = 1'b1;
    end
    chk_cnt++; if (saw_done !== 1'b0) $display("FAIL abort_no_done: got done pulse expected none"); else pass_cnt++;
    start_conv(24'h000777, 1'b1);
    wait_done(cyc);
    chk_cnt++; if (cyc != 7) $display("FAIL after_reset_latency: got %0d expected 7", cyc); else pass_cnt++;
    chk_cnt++; if (number !== -20'sd777) $display("FAIL after_reset_number: got %0d expected -777", number); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_saturation();
    test_error();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_bcd_to_binary
